// File: rtl/mem_arbiter.sv
// Two-master (IFU/LSU) arbiter for a single memory port: one transaction in flight,
// round-robin on ties, per-transaction timeout that returns an error response.
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_W-1:0]     ifu_req_addr,
  output logic                  ifu_rsp_valid,
  output logic [DATA_W-1:0]     ifu_rsp_rdata,
  output logic                  ifu_rsp_err,
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic                  lsu_req_wen,
  input  logic [ADDR_W-1:0]     lsu_req_addr,
  input  logic [DATA_W-1:0]     lsu_req_wdata,
  input  logic [DATA_W/8-1:0]   lsu_req_wmask,
  output logic                  lsu_rsp_valid,
  output logic [DATA_W-1:0]     lsu_rsp_rdata,
  output logic                  lsu_rsp_err,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_wen,
  output logic [ADDR_W-1:0]     mem_req_addr,
  output logic [DATA_W-1:0]     mem_req_wdata,
  output logic [DATA_W/8-1:0]   mem_req_wmask,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_W-1:0]     mem_rsp_rdata,
  input  logic                  mem_rsp_err,
  output logic                  grant_lsu
);

  localparam int unsigned WMASK_W = DATA_W / 8;
  localparam int unsigned CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic               last_grant_q;
  logic               grant_lsu_q;
  logic               wen_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [WMASK_W-1:0] wmask_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               err_q;
  logic [CNT_W-1:0]   cnt_q;

  logic accept_c;
  logic grant_c;
  logic rsp_hit_c;
  logic timeout_c;

  assign timeout_c = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state and arbitration; a response in the timeout cycle takes precedence
  always_comb begin
    state_d   = state_q;
    accept_c  = 1'b0;
    grant_c   = 1'b0;
    rsp_hit_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (ifu_req_valid || lsu_req_valid) begin
          accept_c = 1'b1;
          grant_c  = (ifu_req_valid && lsu_req_valid) ? ~last_grant_q : lsu_req_valid;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (timeout_c)          state_d = RESP;
        else if (mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          rsp_hit_c = 1'b1;
          state_d   = RESP;
        end else if (timeout_c) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, timeout counter and response capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= 1'b1;
      grant_lsu_q  <= 1'b0;
      wen_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      if (accept_c) begin
        last_grant_q <= grant_c;
        grant_lsu_q  <= grant_c;
        if (grant_c) begin
          wen_q   <= lsu_req_wen;
          addr_q  <= lsu_req_addr;
          wdata_q <= lsu_req_wdata;
          wmask_q <= lsu_req_wmask;
        end else begin
          wen_q   <= 1'b0;
          addr_q  <= ifu_req_addr;
          wdata_q <= '0;
          wmask_q <= '0;
        end
      end

      if (accept_c)
        cnt_q <= '0;
      else if ((state_q == ISSUE || state_q == WAIT) && cnt_q != CNT_MAX)
        cnt_q <= cnt_q + CNT_W'(1);

      if (rsp_hit_c) begin
        rdata_q <= (last_grant_q && wen_q) ? '0 : mem_rsp_rdata;
        err_q   <= mem_rsp_err;
      end else if (state_d == RESP && state_q != RESP) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  // Ready is only ever offered in IDLE, and never while reset is asserted
  assign ifu_req_ready = rst && accept_c && !grant_c;
  assign lsu_req_ready = rst && accept_c && grant_c;

  assign mem_req_valid = (state_q == ISSUE);
  assign mem_req_wen   = wen_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wmask = wmask_q;

  assign ifu_rsp_valid = (state_q == RESP) && !last_grant_q;
  assign lsu_rsp_valid = (state_q == RESP) && last_grant_q;
  assign ifu_rsp_rdata = ifu_rsp_valid ? rdata_q : '0;
  assign lsu_rsp_rdata = lsu_rsp_valid ? rdata_q : '0;
  assign ifu_rsp_err   = ifu_rsp_valid && err_q;
  assign lsu_rsp_err   = lsu_rsp_valid && err_q;

  assign grant_lsu = grant_lsu_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: latency, round-robin, stalled issue, timeout,
// mid-transaction reset and error pass-through.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_rsp_valid;
  logic [31:0] ifu_rsp_rdata;
  logic        ifu_rsp_err;
  logic        lsu_req_valid, lsu_req_ready, lsu_req_wen;
  logic [31:0] lsu_req_addr, lsu_req_wdata;
  logic [3:0]  lsu_req_wmask;
  logic        lsu_rsp_valid;
  logic [31:0] lsu_rsp_rdata;
  logic        lsu_rsp_err;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic        mem_rsp_err;
  logic        grant_lsu;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_rdata(ifu_rsp_rdata), .ifu_rsp_err(ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_wen(lsu_req_wen),
    .lsu_req_addr(lsu_req_addr), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_rdata(lsu_rsp_rdata), .lsu_rsp_err(lsu_rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wen(mem_req_wen),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err),
    .grant_lsu(grant_lsu)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Run a granted transaction from cycle 0 to its RESP cycle (3) with a
  // one-cycle memory handshake; the granted master drops valid in cycle 1
  task automatic serve(input logic [31:0] d, input logic e, input logic drop_ifu, input logic drop_lsu);
    nxt();
    if (drop_ifu) ifu_req_valid = 1'b0;
    if (drop_lsu) lsu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    nxt();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = d;
    mem_rsp_err   = e;
    nxt();
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;
    mem_rsp_err   = 1'b0;
    settle();
  endtask

  initial begin
    rst = 1'b0;
    ifu_req_valid = 1'b1; ifu_req_addr = '0;
    lsu_req_valid = 1'b0; lsu_req_wen = 1'b0; lsu_req_addr = '0;
    lsu_req_wdata = '0; lsu_req_wmask = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0; mem_rsp_err = 1'b0;

    // Reset state, with an IFU request already pending
    #23;
    chk("rst_ifu_ready", 64'(ifu_req_ready), 64'd0);
    chk("rst_mem_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_grant_lsu", 64'(grant_lsu), 64'd0);
    chk("rst_rsp_valid", 64'({ifu_rsp_valid, lsu_rsp_valid}), 64'd0);
    nxt();
    ifu_req_valid = 1'b0;
    rst = 1'b1;

    // 1: IFU alone, minimum latency
    nxt();
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000;
    settle();
    chk("t1_accept", 64'({ifu_req_ready, lsu_req_ready}), 64'b10);
    nxt();
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    settle();
    chk("t1_issue", {31'd0, mem_req_valid, mem_req_addr}, {31'd0, 1'b1, 32'h8000_0000});
    chk("t1_issue_wr", 64'({mem_req_wen, mem_req_wmask}), 64'd0);
    nxt();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h0000_0413;
    settle();
    chk("t1_wait", 64'({mem_req_valid, ifu_rsp_valid, lsu_rsp_valid}), 64'd0);
    nxt();
    mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
    settle();
    chk("t1_rsp", {30'd0, ifu_rsp_valid, ifu_rsp_err, ifu_rsp_rdata}, {30'd0, 1'b1, 1'b0, 32'h0000_0413});
    chk("t1_lsu_quiet", 64'({lsu_rsp_valid, grant_lsu}), 64'd0);
    nxt();
    settle();
    chk("t1_pulse_end", 64'(ifu_rsp_valid), 64'd0);

    // 2: round-robin after reset
    rst = 1'b0;
    nxt();
    rst = 1'b1;
    nxt();
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0004;
    lsu_req_valid = 1'b1; lsu_req_wen = 1'b0; lsu_req_addr = 32'h8000_2000;
    settle();
    chk("t2_tie1_ifu", 64'({ifu_req_ready, lsu_req_ready}), 64'b10);
    serve(32'h1111_1111, 1'b0, 1'b1, 1'b0);
    chk("t2_resp_no_ready", 64'({ifu_rsp_valid, lsu_req_ready}), 64'b10);
    nxt();
    ifu_req_valid = 1'b1;
    settle();
    chk("t2_tie2_lsu", 64'({ifu_req_ready, lsu_req_ready, grant_lsu}), 64'b010);
    serve(32'h2222_2222, 1'b0, 1'b0, 1'b1);
    chk("t2_lsu_rsp", {31'd0, lsu_rsp_valid, lsu_rsp_rdata}, {31'd0, 1'b1, 32'h2222_2222});
    nxt();
    lsu_req_valid = 1'b1;
    settle();
    chk("t2_tie3_ifu", 64'({ifu_req_ready, lsu_req_ready}), 64'b10);
    serve(32'h3333_3333, 1'b0, 1'b1, 1'b1);
    chk("t2_ifu_rsp2", {31'd0, ifu_rsp_valid, ifu_rsp_rdata}, {31'd0, 1'b1, 32'h3333_3333});

    // 3: LSU store with memory stalling 5 cycles
    nxt();
    lsu_req_valid = 1'b1; lsu_req_wen = 1'b1; lsu_req_addr = 32'h8000_1000;
    lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wmask = 4'hF;
    settle();
    chk("t3_accept", 64'(lsu_req_ready), 64'd1);
    for (int i = 0; i < 6; i++) begin
      nxt();
      lsu_req_valid = 1'b0; lsu_req_wen = 1'b0; lsu_req_addr = '0;
      lsu_req_wdata = '0; lsu_req_wmask = '0;
      mem_req_ready = (i == 5);
      settle();
      chk($sformatf("t3_hold%0d", i),
          {26'd0, mem_req_valid, mem_req_wen, mem_req_wmask, mem_req_addr},
          {26'd0, 1'b1, 1'b1, 4'hF, 32'h8000_1000});
      chk($sformatf("t3_wdata%0d", i), 64'(mem_req_wdata), 64'hDEAD_BEEF);
    end
    nxt();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hAAAA_5555;
    settle();
    chk("t3_wait", 64'({mem_req_valid, lsu_rsp_valid}), 64'd0);
    nxt();
    mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
    settle();
    chk("t3_rsp", {29'd0, lsu_rsp_valid, lsu_rsp_err, ifu_rsp_valid, lsu_rsp_rdata},
        {29'd0, 1'b1, 1'b0, 1'b0, 32'd0});

    // 4: timeout with TIMEOUT=8
    nxt();
    lsu_req_valid = 1'b1; lsu_req_wen = 1'b0; lsu_req_addr = 32'h8000_3000;
    settle();
    chk("t4_accept", 64'(lsu_req_ready), 64'd1);
    for (int k = 1; k <= 8; k++) begin
      nxt();
      lsu_req_valid = 1'b0;
      mem_req_ready = (k == 1);
      settle();
      chk($sformatf("t4_quiet%0d", k), 64'(lsu_rsp_valid), 64'd0);
    end
    nxt();
    mem_req_ready = 1'b0;
    settle();
    chk("t4_timeout", {30'd0, lsu_rsp_valid, lsu_rsp_err, lsu_rsp_rdata}, {30'd0, 1'b1, 1'b1, 32'd0});
    nxt();
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h5555_AAAA;
    settle();
    chk("t4_late_rsp", 64'({lsu_rsp_valid, ifu_rsp_valid}), 64'd0);
    nxt();
    mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
    settle();
    chk("t4_late_rsp2", 64'({lsu_rsp_valid, mem_req_valid}), 64'd0);

    // 5: reset during WAIT
    nxt();
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_4000;
    settle();
    chk("t5_accept", 64'(lsu_req_ready), 64'd1);
    nxt();
    lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
    nxt();
    mem_req_ready = 1'b0;
    settle();
    chk("t5_in_wait", 64'({mem_req_valid, grant_lsu}), 64'b01);
    rst = 1'b0;
    settle();
    chk("t5_rst_out", 64'({mem_req_valid, grant_lsu, lsu_rsp_valid, ifu_rsp_valid, mem_req_wen}), 64'd0);
    chk("t5_rst_addr", 64'(mem_req_addr), 64'd0);
    nxt();
    rst = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h0BAD_0BAD;
    settle();
    chk("t5_stale1", 64'({lsu_rsp_valid, ifu_rsp_valid}), 64'd0);
    nxt();
    mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
    settle();
    chk("t5_stale2", 64'({lsu_rsp_valid, ifu_rsp_valid}), 64'd0);
    nxt();
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0010;
    settle();
    chk("t5_next_accept", 64'(ifu_req_ready), 64'd1);
    serve(32'h0000_0013, 1'b0, 1'b1, 1'b0);
    chk("t5_next_rsp", {31'd0, ifu_rsp_valid, ifu_rsp_rdata}, {31'd0, 1'b1, 32'h0000_0013});

    // 6: memory error passed through with data
    nxt();
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0020;
    settle();
    chk("t6_accept", 64'(ifu_req_ready), 64'd1);
    serve(32'h1234_5678, 1'b1, 1'b1, 1'b0);
    chk("t6_err_rsp", {30'd0, ifu_rsp_valid, ifu_rsp_err, ifu_rsp_rdata}, {30'd0, 1'b1, 1'b1, 32'h1234_5678});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
